mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 175 +++++++++++++++++
 tb/tb_mdu_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension multiply/divide unit: one radix-2 step per clock,
// shift-add multiply and restoring divide, with sign fixup on completion.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    localparam int IW = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Handshake: a request transfers on an edge where in_valid && in_ready and
    // flush is low; a result transfers on an edge where out_valid && out_ready
    // and flush is low. in_ready is purely the IDLE state, flush gates internally.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign state_dbg = state_q;

    logic              in_is_div;
    logic              s1_neg, s2_neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_ovf;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   calc_result;
    logic              last_iter;

    always_comb begin
        in_is_div = op[2];
        s1_neg    = src1[XLEN-1] && (op == OP_MULH || op == OP_MULHSU ||
                                     op == OP_DIV  || op == OP_REM);
        s2_neg    = src2[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        mag1      = s1_neg ? -src1 : src1;
        mag2      = s2_neg ? -src2 : src2;
        div_ovf   = (op == OP_DIV || op == OP_REM) &&
                    (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == {XLEN{1'b1}});
    end

    // One step of each algorithm; acc holds {high/remainder, low/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, a_q};
        if (!rem_diff[XLEN]) begin
            div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_q ? -mul_next : mul_next;
        quo      = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem      = neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            calc_result = op_q[1] ? rem : quo;
        end else if (op_q == OP_MUL) begin
            calc_result = mul_next[XLEN-1:0];
        end else begin
            calc_result = prod_fix[2*XLEN-1:XLEN];
        end
        last_iter = (iter_q == IW'(XLEN-1));
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        acc_d    = acc_q;
        iter_d   = iter_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    iter_d = '0;
                    if (in_is_div) begin
                        a_d   = mag2;
                        acc_d = {{XLEN{1'b0}}, mag1};
                        // Quotient sign is the xor of operand signs; remainder follows the dividend.
                        neg_d = op[1] ? s1_neg : (s1_neg ^ s2_neg);
                    end else begin
                        a_d   = mag1;
                        acc_d = {{XLEN{1'b0}}, mag2};
                        neg_d = s1_neg ^ s2_neg;
                    end
                    if (in_is_div && src2 == '0) begin
                        result_d = op[1] ? src1 : {XLEN{1'b1}};
                        state_d  = ST_DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? {XLEN{1'b0}} : src1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (last_iter) begin
                        result_d = calc_result;
                        state_d  = ST_DONE;
                    end else begin
                        iter_d = iter_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            iter_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            iter_q   <= iter_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_mdu_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            busy;
    logic [1:0]      state_dbg;

    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    mdu_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint la, lb, lbu, sp;
        logic [63:0] up;
        logic ovf;
        sa  = a;
        sb  = b;
        la  = sa;
        lb  = sb;
        lbu = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin sp = la * lb; up = sp; return up[63:32]; end
            3'd2: begin sp = la * lbu; up = sp; return up[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN;
    endfunction

    // Issue one request and wait for out_valid; lat counts edges after the accept edge.
    task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int lat, output logic busy_ok);
        int w;
        busy_ok = 1'b1;
        lat = 0;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        src1 = $urandom;
        src2 = $urandom;
        while (lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        res = result;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b busy=%b result=%h in_ready=%b, required 0 0 0 1",
                     out_valid, busy, result, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res;
        int lat;
        logic bok;
        drive_op(3'd0, 32'd7, 32'd6, res, lat, bok);
        checks++;
        if (res !== 32'h0000_002A) begin
            failures++;
            $display("FAIL mul_7x6: got %h required 0000002a", res);
        end
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL mul_latency: got %0d required 32", lat);
        end
        checks++;
        if (bok !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mul_busy: busy_ok=%b busy=%b required 1 1", bok, busy);
        end
        take_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_transfer: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops[12]  = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd0};
        logic [31:0] as[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFD};
        logic [31:0] bs[12]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] exps[12] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF1};
        int          lats[12] = '{32, 32, 32, 32, 32, 32, 32, 1, 1, 1, 1, 32};
        logic [31:0] res;
        int lat;
        logic bok;
        for (int i = 0; i < 12; i++) begin
            drive_op(ops[i], as[i], bs[i], res, lat, bok);
            checks++;
            if (res !== exps[i]) begin
                failures++;
                $display("FAIL directed_%0d_op%0d: got %h required %h", i, ops[i], res, exps[i]);
            end
            checks++;
            if (lat !== lats[i]) begin
                failures++;
                $display("FAIL directed_lat_%0d: got %0d required %0d", i, lat, lats[i]);
            end
            take_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        logic bok;
        drive_op(3'd5, 32'd1000, 32'd9, res, lat, bok);
        in_valid = 1'b1;
        op = 3'd0;
        src1 = 32'd2;
        src2 = 32'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd111 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: out_valid=%b result=%h in_ready=%b required 1 0000006f 0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        logic bok;
        int pulses;
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd0;
        src1 = 32'd5;
        src2 = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_calc: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL flush_no_pulse: out_valid pulses=%0d required 0", pulses);
        end
        // flush wins over a simultaneous result transfer
        drive_op(3'd0, 32'd2, 32'd2, res, lat, bok);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_done: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_blocks_accept: busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat;
        logic bok;
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd3;
        src1 = 32'hDEAD_BEEF;
        src2 = 32'h1234_5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: out_valid=%b busy=%b result=%h in_ready=%b required 0 0 0 1",
                     out_valid, busy, result, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready: in_ready=%b required 1", in_ready);
        end
        drive_op(3'd0, 32'd3, 32'd3, res, lat, bok);
        checks++;
        if (res !== 32'd9 || lat !== 32) begin
            failures++;
            $display("FAIL reset_mid_mul: got %h lat %0d required 00000009 lat 32", res, lat);
        end
        take_result();
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, res, exp_v;
        int lat, mode;
        logic bok;
        for (int i = 0; i < 48; i++) begin
            o = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
            else if (mode == 3) a = -($urandom_range(1, 1000));
            exp_q.push_back(ref_model(o, a, b));
            drive_op(o, a, b, res, lat, bok);
            exp_v = exp_q.pop_front();
            checks++;
            if (res !== exp_v) begin
                failures++;
                $display("FAIL random_%0d op%0d a=%h b=%h: got %h required %h", i, o, a, b, res, exp_v);
            end
            checks++;
            if (lat !== ref_latency(o, a, b)) begin
                failures++;
                $display("FAIL random_lat_%0d: got %0d required %0d", i, lat, ref_latency(o, a, b));
            end
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
